// File: rtl/laser_dot_sender.sv
// laser_dot_sender: host-side driver for the laser-treatment engine.
// Buffers 40 host-written dots, resets the engine, streams the dots one per
// cycle, captures the two returned circle centres, re-scores them against the
// stored dots and reports the covered-dot count (or a watchdog timeout).
module laser_dot_sender #(
    parameter int unsigned TIMEOUT = 16'hFFFF,
    parameter int unsigned NPTS    = 40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic       start,
    output logic       busy,
    output logic       LRST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       res_valid,
    output logic [3:0] res_c1x,
    output logic [3:0] res_c1y,
    output logic [3:0] res_c2x,
    output logic [3:0] res_c2y,
    output logic [5:0] res_cover,
    output logic       res_timeout
);

    localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LRST,
        ST_SEND,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } state_t;

    state_t         state;
    logic [3:0]     dot_x [NPTS];
    logic [3:0]     dot_y [NPTS];
    logic [5:0]     k;
    logic [WDW-1:0] wdog;
    logic           hit;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // dx^2 + dy^2 <= 16 with 4-bit deltas, 8-bit squares and a 9-bit sum
    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] d;
        dx = abs_diff(px, cx);
        dy = abs_diff(py, cy);
        sx = {4'b0, dx} * {4'b0, dx};
        sy = {4'b0, dy} * {4'b0, dy};
        d  = {1'b0, sx} + {1'b0, sy};
        return d <= 9'd16;
    endfunction

    // Dot buffer: host writes land only while idle and only for indices below NPTS
    for (genvar i = 0; i < NPTS; i++) begin : g_dot
        always_ff @(posedge CLK) begin
            if (RST) begin
                dot_x[i] <= '0;
                dot_y[i] <= '0;
            end else if (state == ST_IDLE && wr_en && wr_addr == 6'(i)) begin
                dot_x[i] <= wr_x;
                dot_y[i] <= wr_y;
            end
        end
    end

    // Coverage test of the dot currently selected by k against both captured centres
    always_comb begin
        hit = 1'b0;
        if (in_circle(dot_x[k], dot_y[k], res_c1x, res_c1y) ||
            in_circle(dot_x[k], dot_y[k], res_c2x, res_c2y))
            hit = 1'b1;
    end

    // Sequencer: engine reset, dot stream, DONE wait with watchdog, re-score, report
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            LRST        <= 1'b0;
            X           <= '0;
            Y           <= '0;
            k           <= '0;
            wdog        <= '0;
            res_valid   <= 1'b0;
            res_c1x     <= '0;
            res_c1y     <= '0;
            res_c2x     <= '0;
            res_c2y     <= '0;
            res_cover   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // results and watchdog are cleared on entry so they read 0 throughout LRST
                        state       <= ST_LRST;
                        LRST        <= 1'b1;
                        busy        <= 1'b1;
                        k           <= '0;
                        wdog        <= '0;
                        res_c1x     <= '0;
                        res_c1y     <= '0;
                        res_c2x     <= '0;
                        res_c2y     <= '0;
                        res_cover   <= '0;
                        res_timeout <= 1'b0;
                    end
                end
                ST_LRST: begin
                    // X/Y are registered: dot 0 is loaded here and k then runs one dot ahead
                    LRST  <= 1'b0;
                    X     <= dot_x[0];
                    Y     <= dot_y[0];
                    k     <= 6'd1;
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (k == 6'(NPTS)) begin
                        X     <= '0;
                        Y     <= '0;
                        k     <= '0;
                        wdog  <= '0;
                        state <= ST_WAIT;
                    end else begin
                        X <= dot_x[k];
                        Y <= dot_y[k];
                        k <= k + 6'd1;
                    end
                end
                ST_WAIT: begin
                    if (DONE) begin
                        res_c1x <= C1X;
                        res_c1y <= C1Y;
                        res_c2x <= C2X;
                        res_c2y <= C2Y;
                        k       <= '0;
                        state   <= ST_SCORE;
                    end else if (wdog == WDW'(TIMEOUT)) begin
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= ST_REPORT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_SCORE: begin
                    if (hit)
                        res_cover <= res_cover + 6'd1;
                    if (k == 6'(NPTS - 1)) begin
                        k         <= '0;
                        res_valid <= 1'b1;
                        state     <= ST_REPORT;
                    end else begin
                        k <= k + 6'd1;
                    end
                end
                ST_REPORT: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
